axis_downsizer_keep: RTL and testbench
======================================

Name: axis_downsizer_keep

Overview:
AXI-Stream width downsizer, successor to the fixed-ratio downsizer. It splits each wide input beat into DATA_RATIO narrow output words and skips lanes whose keep bit is clear. It places tlast on the final kept lane of a tlast beat and replicates tuser onto every output word. Lane order is selectable. It sits between wide datapath stages and narrow serial sinks inside the same clock domain, and sustains one output word per cycle.

Parameters:
DATA_WIDTH, 8, width of one output word (one lane)
DATA_RATIO, 8, lanes per input beat; legal values 2..64
USER_WIDTH, 1, sideband width, copied unchanged to each output word
LSB_FIRST, 1, 1 = lane 0 (LSBs) emitted first; 0 = lane DATA_RATIO-1 emitted first
S_DATA_WIDTH, DATA_RATIO*DATA_WIDTH, derived input width; do not override

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  asynchronous active-low reset
s_axis_tdata  in  S_DATA_WIDTH  wide input data; lane i = bits [DATA_WIDTH*i +: DATA_WIDTH]
s_axis_tkeep  in  DATA_RATIO  per-lane keep; bit i qualifies lane i
s_axis_tuser  in  USER_WIDTH  input sideband
s_axis_tlast  in  1  end of packet
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  DATA_WIDTH  output word
m_axis_tuser  out  USER_WIDTH  sideband of the source beat
m_axis_tlast  out  1  last word of packet
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready

Behaviour:
- Reset, asynchronous on areset low:
  - m_axis_tvalid = 0, s_axis_tready = 0 while reset is asserted.
  - Beat buffer and remaining-lane mask are cleared; tdata/tuser/tlast registers are set to 0.
  - s_axis_tready rises on the first aclk edge after areset is released.
  - Reset mid-packet discards the buffered beat. No partial word is emitted after reset.
- Storage: one wide beat register (data, user, last) and a DATA_RATIO-bit remaining mask `rem`.
- States: EMPTY (rem == 0) and DRAIN (rem != 0). State is derived from `rem`; there is no separate state register.
- Input accept = s_axis_tvalid && s_axis_tready.
  - On accept: capture data, user and last. rem <= s_axis_tkeep.
  - Null beat (tkeep all zero) with tlast = 0: dropped. rem stays 0 and no output is produced.
  - Null beat with tlast = 1: rem <= one-hot of the first lane in emission order. That single word is emitted with tlast = 1 and whatever data it carries, so packet boundaries are never lost.
- Lane select:
  - sel = lowest set bit of rem when LSB_FIRST = 1, highest set bit when LSB_FIRST = 0.
  - Implemented as a priority encoder; for DATA_RATIO <= 64 it must be pure combinational logic from registers.
- Outputs:
  - m_axis_tvalid = (rem != 0).
  - m_axis_tdata = buffered lane[sel].
  - m_axis_tuser = buffered user.
  - m_axis_tlast = buffered last && (rem has exactly one bit set).
- Output accept = m_axis_tvalid && m_axis_tready. On output accept, bit sel of rem is cleared.
- s_axis_tready = (rem == 0) || (rem one-hot && m_axis_tready).
  - This lets a new beat load in the same cycle the last lane drains.
  - Back-to-back beats with full keep give 100% output utilisation.
  - s_axis_tready depends combinationally on m_axis_tready. This is the only combinational input-to-output path.
- Latency: a beat accepted on edge N presents its first word at m_axis_tvalid after edge N; its first output handshake can occur on edge N+1.
- AXI rules:
  - m_axis_tvalid never deasserts without a handshake.
  - m_axis_tdata, m_axis_tuser and m_axis_tlast are stable while valid && !ready.
- Simultaneous events:
  - Load and drain of the last lane in the same cycle: the load wins and rem is set to the new keep.
  - Load while rem has 2 or more bits set: impossible, because ready = 0.
- Widths: the index register is $clog2(DATA_RATIO) bits wide. The one-hot test is rem != 0 && (rem & (rem-1)) == 0.

Decomposition:
- Package axis_width_pkg:
  - function lane_first(mask, lsb_first) returning the index.
  - function is_onehot(mask).
  - localparam helpers: lane index width = $clog2(DATA_RATIO).
- No sub-module. The priority encoder stays a package function; the buffer and mask form a single always_ff block.

Test Plan:
- Full keep, RATIO=4, DATA_WIDTH=8, beat 0x44332211, tlast=1, ready held 1 -> words 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles; tlast only on 0x44; s_axis_tready high in the 4th cycle.
- Sparse keep 4'b1010 on 0xDDCCBBAA with tlast=1 -> exactly 0xBB, then 0xDD with tlast; 2 output cycles.
- Null beats:
  - keep=0 with tlast=0 -> no output.
  - keep=0 with tlast=1 on data 0x000000EE -> one word 0xEE with tlast=1.
- Back-to-back 16 full beats, random m_axis_tready at 50% -> all 64 words in order with no loss or duplication; valid never drops without a handshake; tuser matches its source beat on every word.
- LSB_FIRST=0, beat 0x44332211 with full keep -> 0x44, 0x33, 0x22, 0x11; tlast on 0x11.
- areset pulled low after 2 of 4 words drained -> m_axis_tvalid=0 asynchronously; after release, the next beat's lane 0 is the first output and no stale words appear.

Source files
------------

// File: rtl/axis_width_pkg.sv
// rtl/axis_width_pkg.sv - lane priority encoding helpers shared by the width converters
package axis_width_pkg;

  localparam int MAX_RATIO = 64;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

  function automatic int lane_idx_w(input int ratio);
    return $clog2(ratio);
  endfunction

  // Index of the first set lane in emission order; 0 when the mask is empty.
  function automatic int lane_first(input logic [MAX_RATIO-1:0] mask, input logic lsb_first);
    int idx;
    idx = 0;
    if (lsb_first) begin
      for (int i = MAX_RATIO - 1; i >= 0; i--) begin
        if (mask[i]) idx = i;
      end
    end else begin
      for (int i = 0; i < MAX_RATIO; i++) begin
        if (mask[i]) idx = i;
      end
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [MAX_RATIO-1:0] mask);
    return (mask != '0) && ((mask & (mask - {{(MAX_RATIO-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/axis_downsizer_keep.sv
// rtl/axis_downsizer_keep.sv - wide-to-narrow AXI-Stream downsizer that skips unkept lanes
module axis_downsizer_keep
  import axis_width_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DATA_RATIO   = 8,
  parameter int USER_WIDTH   = 1,
  parameter int LSB_FIRST    = 1,
  parameter int S_DATA_WIDTH = DATA_RATIO * DATA_WIDTH
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [DATA_RATIO-1:0]   s_axis_tkeep,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);

  localparam int IDX_W = lane_idx_w(DATA_RATIO);

  logic [S_DATA_WIDTH-1:0] buf_data;
  logic [USER_WIDTH-1:0]   buf_user;
  logic                    buf_last;
  logic [DATA_RATIO-1:0]   rem;
  logic                    out_en;

  logic [MAX_RATIO-1:0]    rem_ext;
  logic [IDX_W-1:0]        sel;
  logic [DATA_RATIO-1:0]   sel_mask;
  logic [DATA_RATIO-1:0]   null_mask;
  logic                    rem_onehot;
  drain_state_e            state;
  logic                    s_acc;
  logic                    m_acc;

  always_comb begin
    rem_ext                   = '0;
    rem_ext[DATA_RATIO-1:0]   = rem;
    sel                       = IDX_W'(lane_first(rem_ext, LSB_FIRST != 0));
    rem_onehot                = is_onehot(rem_ext);
    sel_mask                  = '0;
    sel_mask[sel]             = 1'b1;
    // A null tlast beat still needs one word to carry the packet boundary.
    null_mask                 = '0;
    null_mask[(LSB_FIRST != 0) ? 0 : DATA_RATIO - 1] = 1'b1;
    state                     = (rem != '0) ? ST_DRAIN : ST_EMPTY;
  end

  // out_en holds tready low until the first edge after reset release.
  assign s_axis_tready = out_en && ((state == ST_EMPTY) || (rem_onehot && m_axis_tready));
  assign m_axis_tvalid = (state == ST_DRAIN);
  assign m_axis_tdata  = buf_data[int'(sel) * DATA_WIDTH +: DATA_WIDTH];
  assign m_axis_tuser  = buf_user;
  assign m_axis_tlast  = buf_last && rem_onehot;

  assign s_acc = s_axis_tvalid && s_axis_tready;
  assign m_acc = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      buf_data <= '0;
      buf_user <= '0;
      buf_last <= 1'b0;
      rem      <= '0;
      out_en   <= 1'b0;
    end else begin
      out_en <= 1'b1;
      if (s_acc) begin
        buf_data <= s_axis_tdata;
        buf_user <= s_axis_tuser;
        buf_last <= s_axis_tlast;
        if (s_axis_tkeep != '0) begin
          rem <= s_axis_tkeep;
        end else if (s_axis_tlast) begin
          rem <= null_mask;
        end else begin
          rem <= '0;
        end
      end else if (m_acc) begin
        rem <= rem & ~sel_mask;
      end
    end
  end

endmodule

// File: tb/tb_axis_downsizer_keep.sv
// tb/tb_axis_downsizer_keep.sv - self-checking bench for axis_downsizer_keep in both lane orders
module tb_axis_downsizer_keep;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [1:0]  user;
  } beat_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] user;
  } word_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic [1:0]  s_tuser;
  logic        s_tlast;
  logic        s_tvalid;
  logic        m_tready;

  logic        l_s_ready, l_last, l_valid;
  logic [7:0]  l_data;
  logic [1:0]  l_user;
  logic        m_s_ready, m_last, m_valid;
  logic [7:0]  m_data;
  logic [1:0]  m_user;

  int checks   = 0;
  int failures = 0;

  word_t exp_l[$];
  word_t exp_m[$];
  int    pushed;

  always #5 aclk = ~aclk;

  axis_downsizer_keep #(
    .DATA_WIDTH(8), .DATA_RATIO(4), .USER_WIDTH(2), .LSB_FIRST(1)
  ) u_lsb (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(l_s_ready),
    .m_axis_tdata(l_data), .m_axis_tuser(l_user), .m_axis_tlast(l_last),
    .m_axis_tvalid(l_valid), .m_axis_tready(m_tready)
  );

  axis_downsizer_keep #(
    .DATA_WIDTH(8), .DATA_RATIO(4), .USER_WIDTH(2), .LSB_FIRST(0)
  ) u_msb (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(m_s_ready),
    .m_axis_tdata(m_data), .m_axis_tuser(m_user), .m_axis_tlast(m_last),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_tready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: list kept lanes in emission order, mark the final one of a tlast beat.
  task automatic model_push(input beat_t b);
    int    kept[$];
    word_t w;
    for (int o = 0; o < 2; o++) begin
      kept.delete();
      for (int k = 0; k < 4; k++) begin
        int lane;
        lane = (o == 0) ? k : 3 - k;
        if (b.keep[lane]) kept.push_back(lane);
      end
      if (kept.size() == 0 && b.last) kept.push_back((o == 0) ? 0 : 3);
      foreach (kept[j]) begin
        w.data = b.data[8*kept[j] +: 8];
        w.user = b.user;
        w.last = b.last && (j == kept.size() - 1);
        if (o == 0) begin
          exp_l.push_back(w);
          pushed++;
        end else begin
          exp_m.push_back(w);
        end
      end
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] u);
    @(negedge aclk);
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    #1;
    check("send_ready_lsb", l_s_ready, 1);
    check("send_ready_msb", m_s_ready, 1);
    @(posedge aclk);
    #1 s_tvalid = 1'b0;
  endtask

  // Expects n words with m_tready held high; checks the first nshow of them.
  task automatic expect_words(input logic [31:0] lw, input logic [31:0] mw, input logic [1:0] u,
                              input int n, input int nshow);
    for (int k = 0; k < nshow; k++) begin
      @(negedge aclk);
      #1;
      check("dir_valid_lsb", l_valid, 1);
      check("dir_valid_msb", m_valid, 1);
      check("dir_data_lsb", l_data, lw[8*k +: 8]);
      check("dir_data_msb", m_data, mw[8*k +: 8]);
      check("dir_last_lsb", l_last, (k == n - 1));
      check("dir_last_msb", m_last, (k == n - 1));
      check("dir_user_lsb", l_user, u);
      check("dir_user_msb", m_user, u);
      check("dir_sready_lsb", l_s_ready, (k == n - 1));
      check("dir_sready_msb", m_s_ready, (k == n - 1));
      @(posedge aclk);
    end
    if (nshow == n) begin
      @(negedge aclk);
      #1;
      check("dir_idle_lsb", l_valid, 0);
      check("dir_idle_msb", m_valid, 0);
    end
  endtask

  task automatic run_random(input int nbeats, input bit rand_keep, input int ready_pct,
                            output int words);
    beat_t src[$];
    beat_t b;
    word_t got, pl, pm;
    int    si, cyc;
    bit    stall;
    for (int i = 0; i < nbeats; i++) begin
      b.data = $urandom;
      b.keep = rand_keep ? 4'($urandom_range(0, 15)) : 4'hF;
      b.last = rand_keep ? 1'($urandom_range(0, 1)) : (i % 4 == 3);
      b.user = 2'($urandom_range(0, 3));
      src.push_back(b);
    end
    exp_l.delete();
    exp_m.delete();
    pushed = 0;
    words  = 0;
    si     = 0;
    cyc    = 0;
    stall  = 0;
    while ((si < src.size() || exp_l.size() != 0) && cyc < 3000) begin
      @(negedge aclk);
      s_tvalid = (si < src.size());
      if (si < src.size()) begin
        s_tdata = src[si].data;
        s_tkeep = src[si].keep;
        s_tlast = src[si].last;
        s_tuser = src[si].user;
      end
      m_tready = ($urandom_range(0, 99) < ready_pct);
      #1;
      if (stall) begin
        check("hold_valid_lsb", l_valid, 1);
        check("hold_valid_msb", m_valid, 1);
        check("hold_word_lsb", {l_data, l_last, l_user}, {pl.data, pl.last, pl.user});
        check("hold_word_msb", {m_data, m_last, m_user}, {pm.data, pm.last, pm.user});
      end
      check("valid_lsb", l_valid, exp_l.size() != 0);
      check("valid_msb", m_valid, exp_m.size() != 0);
      check("sready_lsb", l_s_ready, exp_l.size() == 0 || (exp_l.size() == 1 && m_tready));
      check("sready_msb", m_s_ready, exp_m.size() == 0 || (exp_m.size() == 1 && m_tready));
      if (l_valid && m_tready) begin
        if (exp_l.size() == 0) begin
          check("spurious_lsb", l_valid, 0);
        end else begin
          got = exp_l.pop_front();
          check("word_lsb", {l_data, l_last, l_user}, {got.data, got.last, got.user});
          words++;
        end
      end
      if (m_valid && m_tready) begin
        if (exp_m.size() == 0) begin
          check("spurious_msb", m_valid, 0);
        end else begin
          got = exp_m.pop_front();
          check("word_msb", {m_data, m_last, m_user}, {got.data, got.last, got.user});
        end
      end
      if (s_tvalid && l_s_ready) begin
        model_push(src[si]);
        si++;
      end
      stall   = l_valid && !m_tready;
      pl.data = l_data;  pl.last = l_last;  pl.user = l_user;
      pm.data = m_data;  pm.last = m_last;  pm.user = m_user;
      cyc++;
      @(posedge aclk);
    end
    #1 s_tvalid = 1'b0;
    check("budget_ok", cyc < 3000, 1);
    check("drained_lsb", exp_l.size(), 0);
    check("drained_msb", exp_m.size(), 0);
    check("word_count", words, pushed);
  endtask

  initial begin
    int nwords;
    areset   = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tuser  = '0;
    m_tready = 1'b1;

    // Reset state
    @(negedge aclk);
    @(negedge aclk);
    #1;
    check("rst_valid_lsb", l_valid, 0);
    check("rst_valid_msb", m_valid, 0);
    check("rst_sready_lsb", l_s_ready, 0);
    check("rst_sready_msb", m_s_ready, 0);
    check("rst_data_lsb", l_data, 0);
    check("rst_last_lsb", l_last, 0);
    @(negedge aclk);
    areset = 1'b1;
    #1;
    check("rel_sready_lsb", l_s_ready, 0);
    @(posedge aclk);
    #1;
    check("rel_sready_up_lsb", l_s_ready, 1);
    check("rel_sready_up_msb", m_s_ready, 1);

    // Full keep, tlast
    send(32'h44332211, 4'hF, 1'b1, 2'd2);
    expect_words(32'h44332211, 32'h11223344, 2'd2, 4, 4);

    // Sparse keep 1010
    send(32'hDDCCBBAA, 4'b1010, 1'b1, 2'd1);
    expect_words(32'h0000DDBB, 32'h0000BBDD, 2'd1, 2, 2);

    // Null beat without tlast: dropped
    send(32'h12345678, 4'h0, 1'b0, 2'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      #1;
      check("null_idle_lsb", l_valid, 0);
      check("null_idle_msb", m_valid, 0);
      check("null_sready_lsb", l_s_ready, 1);
    end

    // Null beat with tlast: one word on the first lane in emission order
    send(32'h000000EE, 4'h0, 1'b1, 2'd0);
    expect_words(32'h000000EE, 32'h00000000, 2'd0, 1, 1);

    // Back-to-back full beats, 50% output ready
    run_random(16, 1'b0, 50, nwords);
    check("b2b_word_total", nwords, 64);

    // Random keep / tlast mix
    run_random(40, 1'b1, 60, nwords);

    // Reset mid-beat after 2 of 4 words
    m_tready = 1'b1;
    send(32'h44332211, 4'hF, 1'b1, 2'd1);
    expect_words(32'h44332211, 32'h11223344, 2'd1, 4, 2);
    @(negedge aclk);
    #1;
    check("pre_rst_valid_lsb", l_valid, 1);
    areset = 1'b0;
    #1;
    check("async_rst_valid_lsb", l_valid, 0);
    check("async_rst_valid_msb", m_valid, 0);
    check("async_rst_sready_lsb", l_s_ready, 0);
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b1;
    #1;
    check("rel2_valid_lsb", l_valid, 0);
    check("rel2_sready_lsb", l_s_ready, 0);
    @(posedge aclk);
    #1;
    check("rel2_sready_up", l_s_ready, 1);
    check("rel2_no_stale", l_valid, 0);
    send(32'h88776655, 4'hF, 1'b1, 2'd3);
    expect_words(32'h88776655, 32'h55667788, 2'd3, 4, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
